// File: rtl/nmi_apb_bridge.sv
// Native-memory-interface to APB initiator bridge: one APB transfer per accepted
// request, with a wait-state timeout, error data substitution and a saturating error count.
module nmi_apb_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ADDR_MASK   = 32'h000F_FFFF,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        nmi_valid_i,
    input  logic [31:0] nmi_addr_i,
    input  logic [31:0] nmi_wdata_i,
    input  logic [3:0]  nmi_wstrb_i,
    output logic [31:0] nmi_rdata_o,
    output logic        nmi_ready_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] wait_cnt_r;
    logic [31:0] paddr_r;
    logic [31:0] pwdata_r;
    logic [3:0]  pstrb_r;
    logic        pwrite_r;
    logic [31:0] rdata_r;
    logic        ready_r;
    logic        psel_r;
    logic        penable_r;
    logic        err_r;
    logic [7:0]  err_cnt_r;

    logic        done_s;
    logic        timeout_s;
    logic        enter_resp_s;
    logic        psel_nxt_s;
    logic        penable_nxt_s;
    logic        ready_nxt_s;
    logic        err_nxt_s;
    logic [31:0] resp_data_s;

    // pready wins over a timeout that would fire in the same cycle
    assign done_s       = (state_r == ST_ACCESS) && pready_i;
    assign timeout_s    = (state_r == ST_ACCESS) && !pready_i && (wait_cnt_r == WAIT_LAST);
    assign enter_resp_s = done_s || timeout_s;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (nmi_valid_i) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (enter_resp_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered control outputs and response data
    always_comb begin
        psel_nxt_s    = 1'b0;
        penable_nxt_s = 1'b0;
        ready_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_SETUP:  psel_nxt_s = 1'b1;
            ST_ACCESS: begin
                psel_nxt_s    = 1'b1;
                penable_nxt_s = 1'b1;
            end
            ST_RESP:   ready_nxt_s = 1'b1;
            default:   psel_nxt_s = 1'b0;
        endcase
        err_nxt_s = enter_resp_s && (timeout_s || pslverr_i);
        if (err_nxt_s) begin
            resp_data_s = ERR_DATA;
        end else if (pwrite_r) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = prdata_i;
        end
    end

    // Request capture, wait counter, response and error bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_r <= 16'd0;
            paddr_r    <= 32'h0000_0000;
            pwdata_r   <= 32'h0000_0000;
            pstrb_r    <= 4'b0000;
            pwrite_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            ready_r    <= 1'b0;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            err_r      <= 1'b0;
            err_cnt_r  <= 8'h00;
        end else begin
            if ((state_r == ST_IDLE) && nmi_valid_i) begin
                paddr_r  <= nmi_addr_i & ADDR_MASK;
                pwdata_r <= nmi_wdata_i;
                pstrb_r  <= nmi_wstrb_i;
                pwrite_r <= (nmi_wstrb_i != 4'b0000);
            end
            if (state_r == ST_SETUP) begin
                wait_cnt_r <= 16'd0;
            end else if ((state_r == ST_ACCESS) && !pready_i) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end
            if (enter_resp_s) begin
                rdata_r <= resp_data_s;
            end
            if (err_nxt_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            ready_r   <= ready_nxt_s;
            psel_r    <= psel_nxt_s;
            penable_r <= penable_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign nmi_rdata_o = rdata_r;
    assign nmi_ready_o = ready_r;
    assign psel_o      = psel_r;
    assign penable_o   = penable_r;
    assign pwrite_o    = pwrite_r;
    assign paddr_o     = paddr_r;
    assign pwdata_o    = pwdata_r;
    assign pstrb_o     = pstrb_r;
    assign err_o       = err_r;
    assign err_cnt_o   = err_cnt_r;

endmodule
